countdown_timer: RTL and testbench

- Loadable down-counter with a valid/ready load handshake, optional auto-reload and a one-cycle expiry pulse.
- Complements the existing up-counter: software on the Ruby side loads a duration, and the block counts it down and signals expiry.
- Sits beside the counter in the sample designs and is driven by a bench through the same relay-per-clock scheme.

---
 rtl/countdown_pkg.sv | 14 +
 rtl/countdown_timer.sv | 110 +++++++++++
 tb/tb_countdown_timer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer and the up-counter sample.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package countdown_pkg;

    // Width shared with the up-counter sample so both blocks default to the same count size.
    localparam int DEFAULT_SIZE = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with an optional auto-reload and a one-cycle expiry pulse.
// Latency: a load of N>0 expires N enabled cycles after acceptance; a load of 0 expires the next cycle.
// Backpressure: load_ready is low while a countdown runs; loads offered then are dropped, not queued.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   load_valid/ready   load handshake; load_value and load_auto are sampled only on acceptance
//   enable             permits one decrement this cycle
//   abort              cancels a running countdown without an expiry pulse
//   count, busy        current count, high while running
//   expire             one-cycle pulse in the cycle after a terminal event
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int Size = DEFAULT_SIZE
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic [Size-1:0] load_value,
    input  logic            load_auto,
    input  logic            enable,
    input  logic            abort,
    output logic [Size-1:0] count,
    output logic            busy,
    output logic            expire
);

    localparam logic [Size-1:0] ONE = Size'(1);

    state_t          state, state_nxt;
    logic [Size-1:0] count_nxt;
    logic [Size-1:0] reload_reg, reload_nxt;
    logic            auto_reg, auto_nxt;
    logic            expire_nxt;

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            auto_reg   <= 1'b0;
            expire     <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            auto_reg   <= auto_nxt;
            expire     <= expire_nxt;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        auto_nxt   = auto_reg;
        expire_nxt = 1'b0;

        unique case (state)
            IDLE: begin
                // load_ready is implied by being in IDLE.
                if (load_valid) begin
                    count_nxt  = load_value;
                    reload_nxt = load_value;
                    if (load_value != '0) begin
                        auto_nxt  = load_auto;
                        state_nxt = RUN;
                    end else begin
                        // A zero load expires at once and must never reload.
                        auto_nxt   = 1'b0;
                        expire_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    // Abort outranks a simultaneous terminal decrement: no pulse.
                    count_nxt = '0;
                    auto_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else if (enable) begin
                    if (count > ONE) begin
                        count_nxt = count - ONE;
                    end else begin
                        // In RUN the count is never 0, so this is the terminal count of 1.
                        expire_nxt = 1'b1;
                        if (auto_reg) begin
                            count_nxt = reload_reg;
                        end else begin
                            count_nxt = '0;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs derived from registered state only.
    always_comb begin
        busy       = (state == RUN);
        load_ready = (state == IDLE);
    end

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    logic       clock;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [4:0] load_value;
    logic       load_auto;
    logic       enable;
    logic       abort;
    logic [4:0] count;
    logic       busy;
    logic       expire;

    int n_chk  = 0;
    int n_pass = 0;

    countdown_timer #(.Size(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .load_auto  (load_auto),
        .enable     (enable),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .expire     (expire)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int val, input logic au);
        load_valid = 1'b1;
        load_value = 5'(val);
        load_auto  = au;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        load_valid = 1'b1;
        load_value = 5'd7;
        load_auto  = 1'b0;
        enable     = 1'b1;
        abort      = 1'b0;

        // Reset held low for 3 cycles with a load offered.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_count", int'(count), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_expire", int'(expire), 0);
            chk("rst_ready", int'(load_ready), 1);
        end
        reset = 1'b1;
        tick();
        chk("rel_count", int'(count), 7);
        chk("rel_busy", int'(busy), 1);
        chk("rel_ready", int'(load_ready), 0);
        load_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("rel_abort_busy", int'(busy), 0);

        // Basic countdown from 5.
        load(5, 1'b0);
        chk("basic_load", int'(count), 5);
        chk("basic_exp0", int'(expire), 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("basic_count", int'(count), 5 - k);
            chk("basic_expire", int'(expire), (k == 5) ? 1 : 0);
            chk("basic_busy", int'(busy), (k == 5) ? 0 : 1);
        end
        chk("basic_ready", int'(load_ready), 1);
        tick();
        chk("basic_exp_once", int'(expire), 0);

        // Auto-reload: 4 periods of 3.
        load(3, 1'b1);
        chk("auto_load", int'(count), 3);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("auto_count", int'(count), (k % 3 == 0) ? 3 : 3 - (k % 3));
            chk("auto_expire", int'(expire), (k % 3 == 0) ? 1 : 0);
            chk("auto_busy", int'(busy), 1);
        end
        // Pause 2 cycles at count 2.
        tick();
        chk("pause_c2", int'(count), 2);
        enable = 1'b0;
        tick();
        chk("pause_hold1", int'(count), 2);
        tick();
        chk("pause_hold2", int'(count), 2);
        chk("pause_noexp", int'(expire), 0);
        enable = 1'b1;
        tick();
        chk("pause_c1", int'(count), 1);
        chk("pause_c1_exp", int'(expire), 0);
        tick();
        chk("pause_reload", int'(count), 3);
        chk("pause_expire", int'(expire), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("auto_abort_count", int'(count), 0);
        chk("auto_abort_busy", int'(busy), 0);
        chk("auto_abort_exp", int'(expire), 0);

        // Abort priority and load ignored while running.
        load(4, 1'b0);
        tick();
        chk("ab_c3", int'(count), 3);
        load_valid = 1'b1;
        load_value = 5'd9;
        tick();
        load_valid = 1'b0;
        chk("ab_ignored", int'(count), 2);
        chk("ab_ready_run", int'(load_ready), 0);
        tick();
        chk("ab_c1", int'(count), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_count", int'(count), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_expire", int'(expire), 0);
        tick();
        chk("ab_expire_late", int'(expire), 0);
        // Abort in IDLE has no effect on a following load.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_ready", int'(load_ready), 1);

        // Zero load with auto requested.
        load(0, 1'b1);
        chk("zero_expire", int'(expire), 1);
        chk("zero_busy", int'(busy), 0);
        chk("zero_count", int'(count), 0);
        tick();
        chk("zero_expire2", int'(expire), 0);
        chk("zero_busy2", int'(busy), 0);
        chk("zero_count2", int'(count), 0);

        // Maximum load.
        load(31, 1'b0);
        chk("max_load", int'(count), 31);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("max_count", int'(count), 31 - k);
            chk("max_expire", int'(expire), (k == 31) ? 1 : 0);
        end
        tick();
        chk("max_no_wrap", int'(count), 0);
        chk("max_idle", int'(busy), 0);

        // Asynchronous reset mid-run.
        load(20, 1'b0);
        for (int k = 0; k < 8; k++) tick();
        chk("ar_c12", int'(count), 12);
        #2 reset = 1'b0;
        #1;
        chk("ar_count", int'(count), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_ready", int'(load_ready), 1);
        chk("ar_expire", int'(expire), 0);
        tick();
        reset = 1'b1;
        load(2, 1'b0);
        chk("ar_load2", int'(count), 2);
        tick();
        chk("ar_c1", int'(count), 1);
        chk("ar_exp0", int'(expire), 0);
        tick();
        chk("ar_c0", int'(count), 0);
        chk("ar_exp1", int'(expire), 1);

        // Reset clears a pending expire pulse.
        load(0, 1'b0);
        chk("pend_expire", int'(expire), 1);
        #2 reset = 1'b0;
        #1;
        chk("pend_cleared", int'(expire), 0);
        tick();
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
